// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   div_state_t : divider sequencer states (IDLE, BUSY, DONE)
//   FWD_*       : EX operand mux selects, also used by the datapath operand muxes
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;  // register file read data
  localparam logic [1:0] FWD_MEM = 2'b01;  // EX/MEM ALU result
  localparam logic [1:0] FWD_WB  = 2'b10;  // MEM/WB write-back result

endpackage

// File: rtl/div_busy_timer.sv
// Iterative-divider sequencer: IDLE -> BUSY (DIV_LAT cycles) -> DONE -> IDLE.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   launch   : request to start a divide (honoured only in IDLE)
//   busy     : pipeline must freeze (includes the launch cycle)
//   done     : divider result valid this cycle
//   start    : one-cycle divider launch pulse
import pipe_ctrl_pkg::*;

module div_busy_timer #(
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic launch,
  output logic busy,
  output logic done,
  output logic start
);

  localparam logic [CNT_W-1:0] LOAD = CNT_W'(DIV_LAT - 1);

  div_state_t       r_state;
  div_state_t       w_next;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && launch) begin
        r_cnt <= LOAD;
      end else if (r_state == BUSY) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // The launch cycle is the first frozen cycle, so the registered BUSY
  // state covers the remaining DIV_LAT-1 cycles; leave BUSY on the cycle
  // the countdown reaches zero.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (launch) w_next = BUSY;
      BUSY:    if (r_cnt == CNT_W'(1)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    start = !rst && (r_state == IDLE) && launch;
    busy  = !rst && ((r_state == BUSY) || start);
    done  = !rst && (r_state == DONE);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   rs_id/rt_id, use_rs_id/use_rt_id, branch_taken_id : ID-stage operands/branch
//   rs_ex/rt_ex, write_ex, is_lw_ex, is_div_ex, w_addr_ex : EX-stage info
//   write_mem, is_lw_mem, w_addr_mem, write_wb, w_addr_wb : MEM/WB writers
//   pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush : stage controls
//   fwd_a_sel, fwd_b_sel          : EX operand source selects
//   div_start, div_done           : divider launch pulse / result valid
//   stall_cycles                  : saturating count of pc_stall cycles
import pipe_ctrl_pkg::*;

module pipe_hazard_ctrl #(
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs_id,
  input  logic [4:0]  rt_id,
  input  logic        use_rs_id,
  input  logic        use_rt_id,
  input  logic        branch_taken_id,
  input  logic [4:0]  rs_ex,
  input  logic [4:0]  rt_ex,
  input  logic        write_ex,
  input  logic        is_lw_ex,
  input  logic        is_div_ex,
  input  logic [4:0]  w_addr_ex,
  input  logic        write_mem,
  input  logic        is_lw_mem,
  input  logic [4:0]  w_addr_mem,
  input  logic        write_wb,
  input  logic [4:0]  w_addr_wb,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_stall,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic        div_start,
  output logic        div_done,
  output logic [31:0] stall_cycles
);

  logic        w_ld_raw;
  logic        w_load_use;
  logic        w_launch;
  logic        w_busy;
  logic        w_done;
  logic        w_start;
  logic [31:0] r_stall_cycles;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // A loaded value is not yet in EX/MEM, so a lw in MEM never forwards;
  // the load-use stall already pushed the consumer back to pick it up from WB.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (write_mem && !is_lw_mem && (w_addr_mem != 5'd0) && (w_addr_mem == src))
      return FWD_MEM;
    else if (write_wb && (w_addr_wb != 5'd0) && (w_addr_wb == src))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  // Raw load-use match is kept free of divider state so the launch gate
  // below does not form a combinational loop through the timer.
  assign w_ld_raw = is_lw_ex && write_ex && (w_addr_ex != 5'd0) &&
                    ((use_rs_id && (rs_id == w_addr_ex)) ||
                     (use_rt_id && (rt_id == w_addr_ex)));

  assign w_launch   = is_div_ex && !w_ld_raw;
  assign w_load_use = !rst && w_ld_raw && !w_busy && !w_done;

  div_busy_timer #(
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_div_timer (
    .clk    (clk),
    .rst    (rst),
    .launch (w_launch),
    .busy   (w_busy),
    .done   (w_done),
    .start  (w_start)
  );

  always_comb begin
    pc_stall     = w_busy || w_load_use;
    if_id_stall  = w_busy || w_load_use;
    id_ex_stall  = w_busy;
    id_ex_flush  = w_load_use;
    ex_mem_flush = w_busy;
    // A redirect while ID is held would discard the stalled instruction.
    if_id_flush  = !rst && branch_taken_id && !if_id_stall;
    fwd_a_sel    = rst ? FWD_RF : fwd_sel(rs_ex);
    fwd_b_sel    = rst ? FWD_RF : fwd_sel(rt_ex);
    div_start    = w_start;
    div_done     = w_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= 32'd0;
    end else if (pc_stall) begin
      r_stall_cycles <= sat_inc(r_stall_cycles);
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (DIV_LAT=4).
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs_id, rt_id, rs_ex, rt_ex, w_addr_ex, w_addr_mem, w_addr_wb;
  logic        use_rs_id, use_rt_id, branch_taken_id;
  logic        write_ex, is_lw_ex, is_div_ex, write_mem, is_lw_mem, write_wb;
  logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        div_start, div_done;
  logic [31:0] stall_cycles;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.DIV_LAT(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .rs_id(rs_id), .rt_id(rt_id), .use_rs_id(use_rs_id), .use_rt_id(use_rt_id),
    .branch_taken_id(branch_taken_id),
    .rs_ex(rs_ex), .rt_ex(rt_ex), .write_ex(write_ex), .is_lw_ex(is_lw_ex),
    .is_div_ex(is_div_ex), .w_addr_ex(w_addr_ex),
    .write_mem(write_mem), .is_lw_mem(is_lw_mem), .w_addr_mem(w_addr_mem),
    .write_wb(write_wb), .w_addr_wb(w_addr_wb),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .div_start(div_start), .div_done(div_done), .stall_cycles(stall_cycles)
  );

  // Expected output word:
  // [11]pc_stall [10]if_id_stall [9]if_id_flush [8]id_ex_stall [7]id_ex_flush
  // [6]ex_mem_flush [5:4]fwd_a [3:2]fwd_b [1]div_start [0]div_done
  typedef struct {
    logic [4:0]  rs_id, rt_id;
    logic        use_rs, use_rt, br;
    logic [4:0]  rs_ex, rt_ex;
    logic        wr_ex, lw_ex;
    logic [4:0]  wa_ex;
    logic        wr_mem, lw_mem;
    logic [4:0]  wa_mem;
    logic        wr_wb;
    logic [4:0]  wa_wb;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl [15];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(int a_rs_id, int a_rt_id, int a_use_rs, int a_use_rt, int a_br,
                              int a_rs_ex, int a_rt_ex, int a_wr_ex, int a_lw_ex, int a_wa_ex,
                              int a_wr_mem, int a_lw_mem, int a_wa_mem, int a_wr_wb, int a_wa_wb,
                              logic [11:0] a_exp);
    vec_t v;
    v.rs_id  = 5'(a_rs_id);  v.rt_id  = 5'(a_rt_id);
    v.use_rs = 1'(a_use_rs); v.use_rt = 1'(a_use_rt); v.br = 1'(a_br);
    v.rs_ex  = 5'(a_rs_ex);  v.rt_ex  = 5'(a_rt_ex);
    v.wr_ex  = 1'(a_wr_ex);  v.lw_ex  = 1'(a_lw_ex);  v.wa_ex = 5'(a_wa_ex);
    v.wr_mem = 1'(a_wr_mem); v.lw_mem = 1'(a_lw_mem); v.wa_mem = 5'(a_wa_mem);
    v.wr_wb  = 1'(a_wr_wb);  v.wa_wb  = 5'(a_wa_wb);
    v.exp    = a_exp;
    return v;
  endfunction

  function automatic logic [11:0] outs();
    return {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush,
            fwd_a_sel, fwd_b_sel, div_start, div_done};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic clr();
    rs_id = 0; rt_id = 0; use_rs_id = 0; use_rt_id = 0; branch_taken_id = 0;
    rs_ex = 0; rt_ex = 0; write_ex = 0; is_lw_ex = 0; is_div_ex = 0; w_addr_ex = 0;
    write_mem = 0; is_lw_mem = 0; w_addr_mem = 0; write_wb = 0; w_addr_wb = 0;
  endtask

  task automatic apply(input vec_t v);
    rs_id = v.rs_id; rt_id = v.rt_id; use_rs_id = v.use_rs; use_rt_id = v.use_rt;
    branch_taken_id = v.br; rs_ex = v.rs_ex; rt_ex = v.rt_ex;
    write_ex = v.wr_ex; is_lw_ex = v.lw_ex; is_div_ex = 1'b0; w_addr_ex = v.wa_ex;
    write_mem = v.wr_mem; is_lw_mem = v.lw_mem; w_addr_mem = v.wa_mem;
    write_wb = v.wr_wb; w_addr_wb = v.wa_wb;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use();
    is_lw_ex = 1; write_ex = 1; w_addr_ex = 5'd2; rs_id = 5'd2; use_rs_id = 1;
  endtask

  initial begin
    tbl[0]  = mk(0,0,0,0,0, 0,0, 0,0,0, 0,0,0, 0,0, 12'h000);
    tbl[1]  = mk(2,0,1,0,0, 0,0, 1,1,2, 0,0,0, 0,0, 12'hC80);
    tbl[2]  = mk(2,0,0,0,0, 0,0, 1,1,2, 0,0,0, 0,0, 12'h000);
    tbl[3]  = mk(0,2,0,1,0, 0,0, 1,1,2, 0,0,0, 0,0, 12'hC80);
    tbl[4]  = mk(0,0,1,1,0, 0,0, 1,1,0, 0,0,0, 0,0, 12'h000);
    tbl[5]  = mk(2,0,1,0,0, 0,0, 0,1,2, 0,0,0, 0,0, 12'h000);
    tbl[6]  = mk(0,0,0,0,0, 5,0, 0,0,0, 1,0,5, 1,5, 12'h010);
    tbl[7]  = mk(0,0,0,0,0, 5,0, 0,0,0, 0,0,5, 1,5, 12'h020);
    tbl[8]  = mk(0,0,0,0,0, 0,0, 0,0,0, 1,0,0, 1,0, 12'h000);
    tbl[9]  = mk(0,0,0,0,0, 5,0, 0,0,0, 1,1,5, 1,5, 12'h020);
    tbl[10] = mk(0,0,0,0,0, 3,5, 0,0,0, 1,0,5, 0,0, 12'h004);
    tbl[11] = mk(0,0,0,0,0, 7,7, 0,0,0, 0,0,0, 1,7, 12'h028);
    tbl[12] = mk(0,0,0,0,1, 0,0, 0,0,0, 0,0,0, 0,0, 12'h200);
    tbl[13] = mk(2,0,1,0,1, 0,0, 1,1,2, 0,0,0, 0,0, 12'hC80);
    tbl[14] = mk(2,3,1,0,0, 0,0, 1,1,3, 0,0,0, 0,0, 12'h000);

    // Reset with hazard-inducing inputs: everything must stay low.
    rst = 1; clr();
    set_load_use(); is_div_ex = 1; branch_taken_id = 1;
    write_mem = 1; w_addr_mem = 5'd4; rs_ex = 5'd4;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {20'd0, outs()}, 32'd0);
    chk("reset_cnt", stall_cycles, 32'd0);
    step(); rst = 0; clr();
    @(negedge clk);
    chk("idle_outs", {20'd0, outs()}, 32'd0);

    for (int i = 0; i < 15; i++) begin
      step(); apply(tbl[i]);
      @(negedge clk);
      chk($sformatf("vec%0d", i), {20'd0, outs()}, {20'd0, tbl[i].exp});
    end

    // Load-use coincident with taken branch, then lw moves to MEM, then WB.
    step(); clr(); set_load_use(); branch_taken_id = 1;
    @(negedge clk); chk("lu_branch", {20'd0, outs()}, 32'hC80);
    step(); clr(); rs_id = 5'd2; use_rs_id = 1; branch_taken_id = 1;
    write_mem = 1; is_lw_mem = 1; w_addr_mem = 5'd2;
    @(negedge clk); chk("lu_release_branch", {20'd0, outs()}, 32'h200);
    step(); clr(); rs_ex = 5'd2; write_wb = 1; w_addr_wb = 5'd2;
    @(negedge clk); chk("lu_fwd_wb", {20'd0, outs()}, 32'h020);

    // Divide: launch cycle 0, frozen 0-3, done in 4, idle in 5.
    step(); clr(); rst = 1;
    step(); rst = 0; is_div_ex = 1;
    @(negedge clk); chk("div_c0", {20'd0, outs()}, 32'hD42);
    chk("div_c0_cnt", stall_cycles, 32'd0);
    step(); @(negedge clk); chk("div_c1", {20'd0, outs()}, 32'hD40);
    step(); branch_taken_id = 1;
    @(negedge clk); chk("div_c2_branch", {20'd0, outs()}, 32'hD40);
    step(); branch_taken_id = 0;
    @(negedge clk); chk("div_c3", {20'd0, outs()}, 32'hD40);
    step(); is_div_ex = 0;
    @(negedge clk); chk("div_c4_done", {20'd0, outs()}, 32'h001);
    step(); set_load_use();
    @(negedge clk); chk("div_c5_idle", {20'd0, outs()}, 32'hC80);
    chk("div_stall_cnt", stall_cycles, 32'd4);

    // Reset during BUSY aborts the divide.
    step(); clr(); rst = 1;
    step(); rst = 0; is_div_ex = 1;
    @(negedge clk); chk("abort_c0", {20'd0, outs()}, 32'hD42);
    step(); @(negedge clk); chk("abort_c1", {20'd0, outs()}, 32'hD40);
    step(); rst = 1;
    @(negedge clk); chk("abort_rst_outs", {20'd0, outs()}, 32'd0);
    step(); rst = 0; is_div_ex = 0;
    @(negedge clk); chk("abort_c3_outs", {20'd0, outs()}, 32'd0);
    chk("abort_cnt", stall_cycles, 32'd0);
    for (int k = 0; k < 5; k++) begin
      step(); @(negedge clk);
      chk($sformatf("abort_no_done%0d", k), {20'd0, outs()}, 32'd0);
    end

    // Saturation of stall_cycles.
    step(); clr();
    @(negedge clk);
    force dut.r_stall_cycles = 32'hFFFF_FFFE;
    #1;
    release dut.r_stall_cycles;
    set_load_use();
    @(negedge clk); chk("sat_first", stall_cycles, 32'hFFFF_FFFF);
    @(negedge clk); chk("sat_hold1", stall_cycles, 32'hFFFF_FFFF);
    @(negedge clk); chk("sat_hold2", stall_cycles, 32'hFFFF_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
